// File: rtl/game_countdown_timer.sv
// game_countdown_timer
//   Round countdown driven by the 1 Hz square wave from the VGA clock divider.
//   slow_clk_in is synchronised into the clk domain; each rising edge yields a
//   one-cycle tick that decrements the BCD MM:SS display while running.
//
// Ports
//   clk          system (pixel) clock
//   rst          asynchronous active-high reset
//   slow_clk_in  divided square wave, asynchronous to clk
//   start        pulse: IDLE -> RUN (or straight to EXPIRED at 00:00)
//   pause        level: hold counting while high in RUN/PAUSED
//   load         pulse: reload START_MIN:START_SEC and return to IDLE
//   min_tens, min_ones, sec_tens, sec_ones   BCD display digits
//   running      high in RUN only
//   last_ten     high while remaining time is 00:01..00:10
//   time_up      one-cycle pulse on expiry
module game_countdown_timer #(
  parameter int START_MIN   = 3,
  parameter int START_SEC   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk_in,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       last_ten,
  output logic       time_up
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  localparam logic [3:0] INIT_MT = 4'(START_MIN / 10);
  localparam logic [3:0] INIT_MO = 4'(START_MIN % 10);
  localparam logic [3:0] INIT_ST = 4'(START_SEC / 10);
  localparam logic [3:0] INIT_SO = 4'(START_SEC % 10);
  localparam logic       INIT_LT = (START_MIN == 0) && (START_SEC >= 1) && (START_SEC <= 10);

  state_t state;

  // Synchroniser, edge history and registered tick (tick appears
  // SYNC_STAGES+1 cycles after the slow_clk_in rise).
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_prev;
  logic                   tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      synced_prev <= 1'b0;
      tick        <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
      synced_prev <= sync_q[SYNC_STAGES-1];
      tick        <= sync_q[SYNC_STAGES-1] & ~synced_prev;
    end
  end

  // One-second BCD decrement with borrow ripple.
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       borrow_s, borrow_st, borrow_m;
  logic       at_zero, at_one;

  always_comb begin
    borrow_s  = (sec_ones == 4'd0);
    borrow_st = borrow_s && (sec_tens == 4'd0);
    borrow_m  = borrow_st && (min_ones == 4'd0);
    dec_so    = borrow_s  ? 4'd9 : sec_ones - 4'd1;
    dec_st    = borrow_s  ? ((sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1) : sec_tens;
    dec_mo    = borrow_st ? ((min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1) : min_ones;
    dec_mt    = borrow_m  ? min_tens - 4'd1 : min_tens;
    at_zero   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                (sec_tens == 4'd0) && (sec_ones == 4'd0);
    at_one    = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                (sec_tens == 4'd0) && (sec_ones == 4'd1);
  end

  function automatic logic in_last_ten(input logic [3:0] mt, input logic [3:0] mo,
                                       input logic [3:0] st, input logic [3:0] so);
    return (mt == 4'd0) && (mo == 4'd0) &&
           (((st == 4'd0) && (so != 4'd0)) || ((st == 4'd1) && (so == 4'd0)));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      min_tens <= INIT_MT;
      min_ones <= INIT_MO;
      sec_tens <= INIT_ST;
      sec_ones <= INIT_SO;
      running  <= 1'b0;
      last_ten <= INIT_LT;
      time_up  <= 1'b0;
    end else begin
      time_up <= 1'b0;
      if (load) begin
        state    <= S_IDLE;
        min_tens <= INIT_MT;
        min_ones <= INIT_MO;
        sec_tens <= INIT_ST;
        sec_ones <= INIT_SO;
        running  <= 1'b0;
        last_ten <= INIT_LT;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              if (at_zero) begin
                state   <= S_EXPIRED;
                time_up <= 1'b1;
              end else begin
                state   <= S_RUN;
                running <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (pause) begin
              state   <= S_PAUSED;
              running <= 1'b0;
            end else if (tick && !at_zero) begin
              min_tens <= dec_mt;
              min_ones <= dec_mo;
              sec_tens <= dec_st;
              sec_ones <= dec_so;
              last_ten <= in_last_ten(dec_mt, dec_mo, dec_st, dec_so);
              if (at_one) begin
                state   <= S_EXPIRED;
                running <= 1'b0;
                time_up <= 1'b1;
              end
            end
          end
          S_PAUSED: begin
            if (!pause) begin
              state   <= S_RUN;
              running <= 1'b1;
            end
          end
          S_EXPIRED: begin
            state <= S_EXPIRED;
          end
          default: begin
            state   <= S_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: three instances (00:12, 10:00, 00:00) share
// stimulus; a remaining-seconds model is compared every cycle, plus literal
// checks at the key points of each scenario.
module tb_game_countdown_timer;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slow_clk_in = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic load = 1'b0;

  logic [3:0] d_mt [3];
  logic [3:0] d_mo [3];
  logic [3:0] d_st [3];
  logic [3:0] d_so [3];
  logic       d_run [3];
  logic       d_lt  [3];
  logic       d_tu  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_countdown_timer #(.START_MIN(0), .START_SEC(12), .SYNC_STAGES(SYNC)) u_a (
    .clk(clk), .rst(rst), .slow_clk_in(slow_clk_in), .start(start), .pause(pause), .load(load),
    .min_tens(d_mt[0]), .min_ones(d_mo[0]), .sec_tens(d_st[0]), .sec_ones(d_so[0]),
    .running(d_run[0]), .last_ten(d_lt[0]), .time_up(d_tu[0]));

  game_countdown_timer #(.START_MIN(10), .START_SEC(0), .SYNC_STAGES(SYNC)) u_b (
    .clk(clk), .rst(rst), .slow_clk_in(slow_clk_in), .start(start), .pause(pause), .load(load),
    .min_tens(d_mt[1]), .min_ones(d_mo[1]), .sec_tens(d_st[1]), .sec_ones(d_so[1]),
    .running(d_run[1]), .last_ten(d_lt[1]), .time_up(d_tu[1]));

  game_countdown_timer #(.START_MIN(0), .START_SEC(0), .SYNC_STAGES(SYNC)) u_c (
    .clk(clk), .rst(rst), .slow_clk_in(slow_clk_in), .start(start), .pause(pause), .load(load),
    .min_tens(d_mt[2]), .min_ones(d_mo[2]), .sec_tens(d_st[2]), .sec_ones(d_so[2]),
    .running(d_run[2]), .last_ten(d_lt[2]), .time_up(d_tu[2]));

  // ---------------- behavioural model ----------------
  // Remaining time as plain seconds; state 0=IDLE 1=RUN 2=PAUSED 3=EXPIRED.
  // hist[j] holds the slow_clk_in value sampled j+1 edges ago; a rise sampled
  // SYNC+1 edges before an edge is the tick acting on that edge.
  int              init_rem [3] = '{12, 600, 0};
  int              m_rem [3];
  int              m_st  [3];
  bit              m_tu  [3];
  logic [SYNC+1:0] hist = '0;
  logic            m_tick_next;

  assign m_tick_next = hist[SYNC] & ~hist[SYNC+1];

  always @(posedge clk) begin
    logic tk;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_rem[i] = init_rem[i];
        m_st[i]  = 0;
        m_tu[i]  = 1'b0;
      end
      hist = '0;
    end else begin
      tk = hist[SYNC] & ~hist[SYNC+1];
      for (int i = 0; i < 3; i++) begin
        m_tu[i] = 1'b0;
        if (load) begin
          m_rem[i] = init_rem[i];
          m_st[i]  = 0;
        end else begin
          case (m_st[i])
            0: if (start) begin
                 if (m_rem[i] == 0) begin m_st[i] = 3; m_tu[i] = 1'b1; end
                 else m_st[i] = 1;
               end
            1: if (pause) m_st[i] = 2;
               else if (tk && m_rem[i] > 0) begin
                 m_rem[i] = m_rem[i] - 1;
                 if (m_rem[i] == 0) begin m_st[i] = 3; m_tu[i] = 1'b1; end
               end
            2: if (!pause) m_st[i] = 1;
            default: ;
          endcase
        end
      end
      hist = {hist[SYNC:0], slow_clk_in};
    end
  end

  function automatic logic [15:0] digs(input int i);
    return {d_mt[i], d_mo[i], d_st[i], d_so[i]};
  endfunction

  function automatic logic [18:0] model_vec(input int i);
    int mm, ss;
    logic lt;
    mm = m_rem[i] / 60;
    ss = m_rem[i] % 60;
    lt = (m_rem[i] >= 1) && (m_rem[i] <= 10);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            (m_st[i] == 1), lt, m_tu[i]};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      logic [18:0] act;
      act = {digs(i), d_run[i], d_lt[i], d_tu[i]};
      checks++;
      if (act !== model_vec(i)) begin
        errors++;
        $display("FAIL model_cmp inst%0d t=%0t got=%h exp=%h", i, $time, act, model_vec(i));
      end
      checks++;
      if (d_so[i] > 4'd9 || d_st[i] > 4'd5 || d_mo[i] > 4'd9 || d_mt[i] > 4'd9) begin
        errors++;
        $display("FAIL bcd_legal inst%0d t=%0t digits=%h", i, $time, digs(i));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit auto_slow = 1'b0;
  int ph = 0;
  int per = 8;
  int hi_len = 4;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (auto_slow) begin
      slow_clk_in = (ph < hi_len);
      ph++;
      if (ph >= per) ph = 0;
    end
  endtask

  task automatic wait_digs(input int i, input logic [15:0] v, input int bound, input string name);
    int n = 0;
    while (digs(i) !== v && n < bound) begin step(); n++; end
    if (digs(i) !== v) begin
      errors++;
      $display("FAIL timeout_%s got=%h exp=%h", name, digs(i), v);
    end
  endtask

  task automatic wait_tu(input int i, input int bound, input string name);
    int n = 0;
    while (d_tu[i] !== 1'b1 && n < bound) begin step(); n++; end
    chk(name, d_tu[i], 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1; step(); load = 1'b0;
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int n;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_a_digits", digs(0), 16'h0012);
    chk("reset_b_digits", digs(1), 16'h1000);
    chk("reset_c_digits", digs(2), 16'h0000);
    chk("reset_running", {d_run[0], d_run[1], d_run[2]}, 0);
    chk("reset_time_up", {d_tu[0], d_tu[1], d_tu[2]}, 0);
    chk("reset_last_ten", {d_lt[0], d_lt[1], d_lt[2]}, 0);

    // start coinciding with a tick in IDLE: no decrement on that tick
    repeat (5) step();
    slow_clk_in = 1'b1;
    repeat (SYNC + 1) step();
    chk("model_tick_aligned", m_tick_next, 1);
    pulse_start();
    chk("coincide_a_digits", digs(0), 16'h0012);
    chk("coincide_a_running", d_run[0], 1);
    chk("coincide_b_digits", digs(1), 16'h1000);
    chk("zero_start_time_up", d_tu[2], 1);
    chk("zero_start_running", d_run[2], 0);
    step();
    chk("zero_time_up_single", d_tu[2], 0);
    slow_clk_in = 1'b0;
    repeat (6) step();

    // first decrement latency from the slow_clk rise
    slow_clk_in = 1'b1;
    n = 0;
    while (digs(0) !== 16'h0011 && n < 20) begin step(); n++; end
    chk("first_dec_latency", n, SYNC + 2);
    chk("b_first_dec", digs(1), 16'h0959);
    chk("a_last_ten_at_11", d_lt[0], 0);

    // free-running 8-cycle slow clock
    ph = n; per = 8; hi_len = 4; auto_slow = 1'b1;
    wait_digs(0, 16'h0010, 100, "a_10");
    chk("a_last_ten_at_10", d_lt[0], 1);
    wait_tu(0, 200, "a_time_up");
    chk("a_expired_digits", digs(0), 16'h0000);
    chk("a_expired_running", d_run[0], 0);
    step();
    chk("a_time_up_single", d_tu[0], 0);
    pulse_start();
    repeat (40) step();
    chk("a_expired_hold", digs(0), 16'h0000);
    chk("c_expired_hold", digs(2), 16'h0000);

    // pause coinciding with a tick at 00:30 on instance B
    n = 0;
    while (!(m_rem[1] == 30 && m_tick_next) && n < 6000) begin step(); n++; end
    chk("b_reach_30", m_rem[1], 30);
    pause = 1'b1;
    step();
    chk("pause_tick_digits", digs(1), 16'h0030);
    repeat (24) step();
    chk("pause_hold_digits", digs(1), 16'h0030);
    chk("pause_running", d_run[1], 0);
    pause = 1'b0;
    step();
    wait_digs(1, 16'h0029, 20, "b_29");
    wait_tu(1, 400, "b_time_up");
    chk("b_final_digits", digs(1), 16'h0000);

    // load mid-run and asynchronous reset mid-count
    pulse_load();
    chk("load_a_digits", digs(0), 16'h0012);
    pulse_start();
    wait_digs(0, 16'h0005, 200, "a_05");
    pulse_load();
    chk("load_run_digits", digs(0), 16'h0012);
    chk("load_run_running", d_run[0], 0);
    chk("load_run_time_up", d_tu[0], 0);
    pulse_start();
    wait_digs(0, 16'h0007, 200, "a_07");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_digits", digs(0), 16'h0012);
    chk("async_rst_running", d_run[0], 0);
    chk("async_rst_b_digits", digs(1), 16'h1000);
    step();
    rst = 1'b0;

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 19) == 0);
      load  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      rst   = ($urandom_range(0, 699) == 0);
      if (ph == 0 && $urandom_range(0, 3) == 0) begin
        per    = $urandom_range(2, 12);
        hi_len = $urandom_range(1, per - 1);
      end
      step();
    end
    start = 1'b0; load = 1'b0; pause = 1'b0; rst = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
